sram_fwft_fifo: RTL and testbench

//  First-word-fall-through FIFO controller built around an internal dual-port synchronous RAM.
//  - Write port of the RAM: push side. Read port: pop side.
//  - The RAM has 1-cycle read latency; this block hides it behind valid/ready handshakes on both ends.
//  - Used as the buffering stage between bus-side producers (DMA, camera) and processing consumers.

---
 rtl/sram_fwft_fifo.sv | 108 ++++++++++
 tb/tb_sram_fwft_fifo.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sram_fwft_fifo.sv
// sram_fwft_fifo
// First-word-fall-through FIFO wrapped around a dual-port synchronous RAM.
// The RAM read-port output register drives popData directly, and a one-word
// head slot hides the RAM's one-cycle read latency behind valid/ready on both ends.
module sram_fwft_fifo #(
    parameter int bitwidth        = 32,
    parameter int nrOfEntries     = 512,
    parameter int almostFullLevel = 448
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [bitwidth-1:0]             pushData,
    input  logic                            pushValid,
    output logic                            pushReady,
    output logic [bitwidth-1:0]             popData,
    output logic                            popValid,
    input  logic                            popReady,
    output logic [$clog2(nrOfEntries):0]    fillLevel,
    output logic                            almostFull
);

    localparam int ADDR_W = $clog2(nrOfEntries);
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] FULL_LEVEL   = CNT_W'(nrOfEntries);
    localparam logic [CNT_W-1:0] ALMOST_LEVEL = CNT_W'(almostFullLevel);
    localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);

    // Head-slot states: popValid is simply "head slot holds a word"
    localparam logic [0:0] HEAD_EMPTY = 1'b0;
    localparam logic [0:0] HEAD_VALID = 1'b1;

    logic [bitwidth-1:0] mem [nrOfEntries];

    logic [ADDR_W-1:0] write_ptr;
    logic [ADDR_W-1:0] read_ptr;
    logic [CNT_W-1:0]  ram_count;
    logic [CNT_W-1:0]  ram_count_next;
    logic [CNT_W-1:0]  fill_next;
    logic [0:0]        head_state;
    logic [0:0]        head_state_next;

    logic push_fire;
    logic pop_fire;
    logic read_issue;

    // Handshake qualifiers; pushReady depends only on registers and reset, never on popReady
    always_comb begin
        pushReady  = (fillLevel < FULL_LEVEL) && !reset;
        popValid   = (head_state == HEAD_VALID);
        push_fire  = pushValid && pushReady;
        pop_fire   = popValid && popReady;
        read_issue = (ram_count != '0) && (!popValid || popReady) && !reset;
    end

    // Next-state of the counters and of the head slot
    always_comb begin
        ram_count_next  = ram_count;
        fill_next       = fillLevel;
        head_state_next = head_state;

        case ({push_fire, read_issue})
            2'b10:   ram_count_next = ram_count + ONE;
            2'b01:   ram_count_next = ram_count - ONE;
            default: ram_count_next = ram_count;
        endcase

        case ({push_fire, pop_fire})
            2'b10:   fill_next = fillLevel + ONE;
            2'b01:   fill_next = fillLevel - ONE;
            default: fill_next = fillLevel;
        endcase

        case (head_state)
            HEAD_EMPTY: if (read_issue) head_state_next = HEAD_VALID;
            HEAD_VALID: if (pop_fire && !read_issue) head_state_next = HEAD_EMPTY;
            default:    head_state_next = HEAD_EMPTY;
        endcase
    end

    // Control registers: pointers, counters, head state and the almostFull flag
    always_ff @(posedge clock) begin
        if (reset) begin
            write_ptr  <= '0;
            read_ptr   <= '0;
            ram_count  <= '0;
            fillLevel  <= '0;
            head_state <= HEAD_EMPTY;
            almostFull <= 1'b0;
        end else begin
            if (push_fire)  write_ptr <= write_ptr + 1'b1;
            if (read_issue) read_ptr  <= read_ptr + 1'b1;
            ram_count  <= ram_count_next;
            fillLevel  <= fill_next;
            head_state <= head_state_next;
            almostFull <= (fill_next >= ALMOST_LEVEL);
        end
    end

    // RAM write port and read-port output register; the output only reloads on a
    // read issue, so popData stays stable while the consumer stalls. Total occupancy
    // never exceeds capacity, so a write can never land on the word being held.
    always_ff @(posedge clock) begin
        if (push_fire)  mem[write_ptr] <= pushData;
        if (read_issue) popData        <= mem[read_ptr];
    end

endmodule

// File: tb/tb_sram_fwft_fifo.sv
// tb_sram_fwft_fifo
// Randomised and directed stimulus against a queue-based model of the FIFO:
// words wait in a RAM queue, move to a single head slot one cycle after they
// become visible there, and leave when the consumer takes the head.
module tb_sram_fwft_fifo;

    localparam int N = 8;
    localparam int L = 6;
    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] pushData;
    logic         pushValid;
    logic         pushReady;
    logic [W-1:0] popData;
    logic         popValid;
    logic         popReady;
    logic [3:0]   fillLevel;
    logic         almostFull;

    int totalChecks  = 0;
    int passedChecks = 0;

    logic [W-1:0] ramQ[$];
    logic [W-1:0] headWord;
    bit           headValid;
    int           fill;

    sram_fwft_fifo #(
        .bitwidth(W),
        .nrOfEntries(N),
        .almostFullLevel(L)
    ) dut (
        .clock(clock),
        .reset(reset),
        .pushData(pushData),
        .pushValid(pushValid),
        .pushReady(pushReady),
        .popData(popData),
        .popValid(popValid),
        .popReady(popReady),
        .fillLevel(fillLevel),
        .almostFull(almostFull)
    );

    // Free-running clock
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        totalChecks++;
        if (actual === expected) passedChecks++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    task automatic modelClear();
        ramQ.delete();
        headValid = 1'b0;
        headWord  = '0;
        fill      = 0;
    endtask

    // Drive one cycle of inputs, compare every output against the model, then advance the model
    task automatic applyStimulus(input bit rst, input bit pv, input logic [W-1:0] pd, input bit pr);
        bit doPush;
        bit doPop;
        bit doIssue;
        @(negedge clock);
        reset     = rst;
        pushValid = pv;
        pushData  = pd;
        popReady  = pr;
        #1;
        checkOutput("popValid", W'(popValid), W'(headValid));
        if (headValid) checkOutput("popData", popData, headWord);
        checkOutput("pushReady", W'(pushReady), W'((fill < N) && !rst));
        checkOutput("fillLevel", W'(fillLevel), W'(fill));
        checkOutput("almostFull", W'(almostFull), W'(fill >= L));
        doPush  = pv && (fill < N) && !rst;
        doPop   = headValid && pr && !rst;
        doIssue = (ramQ.size() > 0) && (!headValid || pr) && !rst;
        @(posedge clock);
        if (rst) begin
            modelClear();
        end else begin
            fill = fill + int'(doPush) - int'(doPop);
            if (doIssue) begin
                headWord  = ramQ.pop_front();
                headValid = 1'b1;
            end else if (doPop) begin
                headValid = 1'b0;
            end
            if (doPush) ramQ.push_back(pd);
        end
        #2;
    endtask

    initial begin
        int pushed;
        logic [W-1:0] nextVal;
        bit pv;
        bit pr;

        reset     = 1'b1;
        pushValid = 1'b0;
        popReady  = 1'b0;
        pushData  = '0;
        modelClear();
        repeat (3) @(posedge clock);
        #2;
        checkOutput("resetPopValid", W'(popValid), 32'd0);
        checkOutput("resetFill", W'(fillLevel), 32'd0);
        checkOutput("resetAlmostFull", W'(almostFull), 32'd0);
        checkOutput("resetPushReady", W'(pushReady), 32'd0);

        // Single word: visible after the issue edge that follows the push edge, then held
        applyStimulus(0, 1, 32'hA5, 0);
        checkOutput("t1PopValidEarly", W'(popValid), 32'd0);
        checkOutput("t1Fill", W'(fillLevel), 32'd1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t1PopValid", W'(popValid), 32'd1);
        checkOutput("t1PopData", popData, 32'hA5);
        repeat (5) applyStimulus(0, 0, 0, 0);
        checkOutput("t1Held", popData, 32'hA5);

        // Fill to capacity
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, W'(i), 0);
            if (i == 4) checkOutput("t2AlmostFullOff", W'(almostFull), 32'd0);
            if (i == 5) checkOutput("t2AlmostFullOn", W'(almostFull), 32'd1);
        end
        checkOutput("t2PushReadyFull", W'(pushReady), 32'd0);
        checkOutput("t2FillFull", W'(fillLevel), 32'd8);
        applyStimulus(0, 1, 32'd99, 0);
        checkOutput("t2NinthIgnored", W'(fillLevel), 32'd8);
        checkOutput("t2Head", popData, 32'd0);

        // Stream out of a full FIFO while pushing 100..
        for (int k = 0; k < 24; k++) applyStimulus(0, 1, W'(100 + k), 1);
        repeat (12) applyStimulus(0, 0, 0, 1);

        // Continuous push/pop across pointer wrap
        for (int k = 0; k < 40; k++) applyStimulus(0, 1, W'(200 + k), 1);
        repeat (12) applyStimulus(0, 0, 0, 1);

        // Random handshakes
        pushed  = 0;
        nextVal = 32'h1000;
        for (int c = 0; c < 6000 && pushed < 1000; c++) begin
            pv = 1'($urandom_range(0, 1));
            pr = 1'($urandom_range(0, 1));
            applyStimulus(0, pv, nextVal, pr);
            if (pv && ramQ.size() > 0 && ramQ[ramQ.size()-1] == nextVal) begin
                pushed++;
                nextVal = nextVal + 1;
            end
        end
        repeat (12) applyStimulus(0, 0, 0, 1);

        // Reset in the middle of traffic
        for (int k = 0; k < 5; k++) applyStimulus(0, 1, W'(32'h300 + k), 0);
        applyStimulus(1, 1, 32'h999, 1);
        reset     = 1'b0;
        pushValid = 1'b0;
        popReady  = 1'b0;
        #1;
        checkOutput("t6PopValid", W'(popValid), 32'd0);
        checkOutput("t6Fill", W'(fillLevel), 32'd0);
        checkOutput("t6PushReady", W'(pushReady), 32'd1);
        applyStimulus(0, 1, 32'h77, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t6FirstWordValid", W'(popValid), 32'd1);
        checkOutput("t6FirstWord", popData, 32'h77);
        applyStimulus(0, 0, 0, 1);

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
